// File: rtl/vram_scanout.sv
// vram_scanout: 640x480@60 VGA scanout of the 512x256 Hack screen.
// The timing counters drive the registered sync and active outputs. The same
// counters drive a two-cycle VRAM fetch for each 16-pixel word, followed by a
// holding register and a shift register that feed the pixel output. The image
// sits in a window inside the visible area, and the area around it is black.
// Scanout begins only at a frame start that sees `loaded` high.
module vram_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int IMG_X     = 64,   // first image column, must be >= 3
    parameter int IMG_Y     = 112,  // first image line
    parameter int IMG_WORDS = 32,   // words fetched per image line
    parameter int IMG_LINES = 256   // image lines per frame
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        loaded,
    output logic        rden,
    output logic [13:0] raddr,
    input  logic [15:0] rdata,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        pixel
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST    = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST    = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] IMG_X_FIRST = 10'(IMG_X);
    localparam logic [9:0] IMG_X_END   = 10'(IMG_X + 16 * IMG_WORDS);
    localparam logic [9:0] IMG_Y_FIRST = 10'(IMG_Y);
    localparam logic [9:0] IMG_Y_END   = 10'(IMG_Y + IMG_LINES);
    // The address register is loaded one cycle before the address appears on
    // the port. Word k therefore loads at IMG_X+16k-3 and again at IMG_X+16k-2.
    localparam logic [9:0] FETCH_FIRST = 10'(IMG_X - 3);
    localparam logic [9:0] FETCH_LAST  = 10'(IMG_X + 16 * IMG_WORDS - 18);

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        scan_en;
    logic [15:0] hold;
    logic [15:0] shifter;

    logic        frame_start;
    logic        img_line;
    logic        img_col;
    logic        fetch_slot;
    logic        capture;
    logic        load;
    logic        cur_bit;
    logic [8:0]  fetch_off;
    logic [3:0]  x_phase;
    logic [7:0]  y_line;

    // Decode the counter position into window, fetch and load strobes.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no latches are inferred.
        frame_start = 1'b0;
        img_line    = 1'b0;
        img_col     = 1'b0;
        fetch_slot  = 1'b0;
        capture     = 1'b0;
        load        = 1'b0;
        fetch_off   = 9'(hcount - FETCH_FIRST);
        x_phase     = 4'(hcount - IMG_X_FIRST);
        y_line      = 8'(vcount - IMG_Y_FIRST);

        frame_start = (hcount == 10'd0) && (vcount == 10'd0);
        img_line    = (vcount >= IMG_Y_FIRST) && (vcount < IMG_Y_END);
        img_col     = (hcount >= IMG_X_FIRST) && (hcount < IMG_X_END);
        fetch_slot  = scan_en && img_line &&
                      (hcount >= FETCH_FIRST) && (hcount <= FETCH_LAST) &&
                      (fetch_off[3:1] == 3'b000);
        // rdata is valid during the second rden cycle of each word.
        capture     = rden && (fetch_off[3:0] == 4'd2);
        load        = img_col && (x_phase == 4'd0);
        // On a load cycle the new word is still in the holding register.
        cur_bit     = load ? hold[0] : shifter[0];
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= 10'd0;
            vcount <= 10'd0;
        end else if (hcount == H_LAST) begin
            // NOTE: state is updated with non-blocking assignments so every block sees pre-edge values.
            hcount <= 10'd0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    // Enable latch. It is sampled only at frame start, so a frame is never torn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_en <= 1'b0;
        end else if (frame_start) begin
            scan_en <= loaded;
        end
    end

    // VRAM read port, holding register and pixel shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data registers are reset too, so no stale word can reach the pixel path after reset.
            rden    <= 1'b0;
            raddr   <= 14'd0;
            hold    <= 16'd0;
            shifter <= 16'd0;
        end else begin
            if (fetch_slot) begin
                rden  <= 1'b1;
                raddr <= {1'b0, y_line, fetch_off[8:4]};
            end else begin
                rden  <= 1'b0;
                raddr <= 14'd0;
            end

            if (capture) begin
                hold <= rdata;
            end

            if (load) begin
                shifter <= {1'b0, hold[15:1]};
            end else begin
                shifter <= {1'b0, shifter[15:1]};
            end
        end
    end

    // Registered video outputs. They lag the counters by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            active <= 1'b0;
            pixel  <= 1'b0;
        end else begin
            hsync  <= !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
            vsync  <= !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
            active <= (hcount < H_VIS) && (vcount < V_VIS);
            // A Hack 1 is black. Border and blanking pixels are forced to black.
            pixel  <= scan_en && img_line && img_col && !cur_bit;
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout: directed bench for vram_scanout.
// The main instance uses a shrunken frame (100x17 total, 64x4 image) so that
// multi-frame scenarios stay short. A second instance keeps the default
// parameters and is checked against the 640x480 horizontal timing.
module tb_vram_scanout;

    localparam int IMG_X     = 8;
    localparam int IMG_Y     = 3;
    localparam int IMG_WORDS = 4;
    localparam int IMG_LINES = 4;
    localparam int H_TOTAL   = 100;
    localparam int V_TOTAL   = 17;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        loaded = 1'b0;
    logic        rden;
    logic [13:0] raddr;
    logic [15:0] rdata = 16'h0;
    logic        hsync, vsync, active, pixel;

    logic        loaded_d = 1'b0;
    logic [15:0] rdata_d = 16'h0;
    logic        rden_d, hsync_d, vsync_d, active_d, pixel_d;
    logic [13:0] raddr_d;

    int mode = 0;          // VRAM contents: 0 word[a]=a, 1 all 0x0001, 2 only word[33]=0x8000
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vram_scanout #(
        .H_VISIBLE(80), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .IMG_X(IMG_X), .IMG_Y(IMG_Y), .IMG_WORDS(IMG_WORDS), .IMG_LINES(IMG_LINES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .loaded(loaded),
        .rden(rden), .raddr(raddr), .rdata(rdata),
        .hsync(hsync), .vsync(vsync), .active(active), .pixel(pixel)
    );

    vram_scanout dut_d (
        .clk(clk), .reset_n(reset_n), .loaded(loaded_d),
        .rden(rden_d), .raddr(raddr_d), .rdata(rdata_d),
        .hsync(hsync_d), .vsync(vsync_d), .active(active_d), .pixel(pixel_d)
    );

    function automatic logic [15:0] vram_word(input int a);
        case (mode)
            1:       return 16'h0001;
            2:       return (a == 33) ? 16'h8000 : 16'h0000;
            default: return a[15:0];
        endcase
    endfunction

    // VRAM model: registered read whose output is zeroed when rden is low.
    always @(posedge clk) begin
        rdata <= rden ? vram_word(int'(raddr)) : 16'h0000;
    end

    function automatic logic exp_hsync(input int h);
        return !(h >= 84 && h <= 91);
    endfunction

    function automatic logic exp_vsync(input int v);
        return !(v >= 12 && v <= 13);
    endfunction

    function automatic logic exp_active(input int h, input int v);
        return (h < 80) && (v < 10);
    endfunction

    function automatic logic exp_pixel(input int h, input int v, input logic scan);
        logic [15:0] w;
        int x, y;
        if (!scan || h < IMG_X || h >= IMG_X + 64 || v < IMG_Y || v >= IMG_Y + IMG_LINES)
            return 1'b0;
        x = h - IMG_X;
        y = v - IMG_Y;
        w = vram_word(y * 32 + x / 16);
        return ~w[x % 16];
    endfunction

    // Reference position: rh/rv mirror the DUT counters during the current
    // cycle, and ph/pv hold the position that the registered outputs show now.
    int   rh, rv, ph, pv;
    logic pvalid, frame_scan;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rh <= 0;
            rv <= 0;
            pvalid <= 1'b0;
            frame_scan <= 1'b0;
        end else begin
            ph <= rh;
            pv <= rv;
            pvalid <= 1'b1;
            if (rh == 0 && rv == 0) frame_scan <= loaded;
            if (rh == H_TOTAL - 1) begin
                rh <= 0;
                rv <= (rv == V_TOTAL - 1) ? 0 : rv + 1;
            end else begin
                rh <= rh + 1;
            end
        end
    end

    // Cycle monitor: accumulates activity counts and deviations from the model.
    int   rd_count = 0, rd_cyc = 0, rd_idx = 0, rd_err = 0;
    int   sync_err = 0, pix_err = 0, hs_low = 0, vs_low = 0, act_cnt = 0, pix_hi = 0;
    logic rden_q = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rd_idx <= 0;
            rden_q <= 1'b0;
        end else begin
            rden_q <= rden;
            if (rh == 0 && rv == 0) rd_idx <= 0;
            if (rden) rd_cyc <= rd_cyc + 1;
            if (rden && !rden_q) begin
                rd_count <= rd_count + 1;
                if (!frame_scan ||
                    int'(raddr) != (rd_idx / IMG_WORDS) * 32 + rd_idx % IMG_WORDS ||
                    rh != IMG_X + 16 * (rd_idx % IMG_WORDS) - 2 ||
                    rv != IMG_Y + rd_idx / IMG_WORDS)
                    rd_err <= rd_err + 1;
                rd_idx <= rd_idx + 1;
            end
            if (pvalid) begin
                sync_err <= sync_err + int'(hsync !== exp_hsync(ph)) + int'(vsync !== exp_vsync(pv))
                            + int'(active !== exp_active(ph, pv));
                pix_err  <= pix_err + int'(pixel !== exp_pixel(ph, pv, frame_scan));
                hs_low   <= hs_low + int'(hsync == 1'b0);
                vs_low   <= vs_low + int'(vsync == 1'b0);
                act_cnt  <= act_cnt + int'(active == 1'b1);
                pix_hi   <= pix_hi + int'(pixel == 1'b1);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait until the DUT counters reach (h, v), then step 1 ns past the negedge.
    task automatic wait_pos(input int h, input int v);
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (rh == h && rv == v) break;
        end
        #1;
        check("wait_pos", 32'(n < 4000), 32'd1);
    endtask

    int s_rd, s_cyc, s_hs, s_vs, s_act, s_pix, s_perr, s_serr;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_rden", 32'(rden), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_hsync_d", 32'(hsync_d), 32'd1);

        // Two frames with loaded=0, plus default-timing horizontal checks.
        @(negedge clk);
        #1 reset_n = 1'b1;
        s_rd = rd_count; s_hs = hs_low; s_vs = vs_low; s_act = act_cnt; s_pix = pix_hi;
        for (int k = 1; k <= 2 * H_TOTAL * V_TOTAL; k++) begin
            @(negedge clk);
            #1;
            if (k == 640) check("dflt_active_639", 32'(active_d), 32'd1);
            if (k == 641) check("dflt_active_640", 32'(active_d), 32'd0);
            if (k == 656) check("dflt_hsync_655", 32'(hsync_d), 32'd1);
            if (k == 657) check("dflt_hsync_656", 32'(hsync_d), 32'd0);
            if (k == 752) check("dflt_hsync_751", 32'(hsync_d), 32'd0);
            if (k == 753) begin
                check("dflt_hsync_752", 32'(hsync_d), 32'd1);
                check("dflt_vsync", 32'(vsync_d), 32'd1);
                check("dflt_rden", 32'(rden_d), 32'd0);
                check("dflt_pixel", 32'(pixel_d), 32'd0);
            end
        end
        check("idle_reads", 32'(rd_count - s_rd), 32'd0);
        check("idle_hs_low", 32'(hs_low - s_hs), 32'd272);
        check("idle_vs_low", 32'(vs_low - s_vs), 32'd400);
        check("idle_active", 32'(act_cnt - s_act), 32'd1600);
        check("idle_pix_hi", 32'(pix_hi - s_pix), 32'd0);

        // loaded rises mid-frame. The rest of that frame stays idle.
        wait_pos(0, 8);
        loaded = 1'b1;
        s_rd = rd_count;
        wait_pos(0, 0);
        check("late_load_no_reads", 32'(rd_count - s_rd), 32'd0);
        s_rd = rd_count; s_cyc = rd_cyc; s_perr = pix_err;
        wait_pos(0, 0);
        check("frame_reads", 32'(rd_count - s_rd), 32'd16);
        check("frame_rden_cycles", 32'(rd_cyc - s_cyc), 32'd32);
        check("frame_pix_mode0", 32'(pix_err - s_perr), 32'd0);

        // All words 0x0001: the leftmost pixel of each group is black.
        mode = 1;
        s_pix = pix_hi;
        wait_pos(IMG_X, IMG_Y);
        check("border_left", 32'(pixel), 32'd0);
        wait_pos(IMG_X + 1, IMG_Y);
        check("m1_x0", 32'(pixel), 32'd0);
        wait_pos(IMG_X + 2, IMG_Y);
        check("m1_x1", 32'(pixel), 32'd1);
        wait_pos(IMG_X + 17, IMG_Y);
        check("m1_x16", 32'(pixel), 32'd0);
        wait_pos(IMG_X + 64, IMG_Y);
        check("m1_x63", 32'(pixel), 32'd1);
        wait_pos(IMG_X + 65, IMG_Y);
        check("border_right", 32'(pixel), 32'd0);
        wait_pos(0, 0);
        check("m1_pix_hi", 32'(pix_hi - s_pix), 32'd240);

        // Only word 33 = 0x8000: a single black pixel at line 1, x'=31.
        mode = 2;
        s_pix = pix_hi;
        wait_pos(IMG_X + 32, IMG_Y);
        check("m2_l0_x31", 32'(pixel), 32'd1);
        wait_pos(IMG_X + 31, IMG_Y + 1);
        check("m2_l1_x30", 32'(pixel), 32'd1);
        wait_pos(IMG_X + 32, IMG_Y + 1);
        check("m2_l1_x31", 32'(pixel), 32'd0);
        wait_pos(IMG_X + 33, IMG_Y + 1);
        check("m2_l1_x32", 32'(pixel), 32'd1);
        wait_pos(0, 0);
        check("m2_pix_hi", 32'(pix_hi - s_pix), 32'd255);

        // Asynchronous reset pulse mid-line, during a read.
        wait_pos(22, 5);
        check("pre_rst_rden", 32'(rden), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_hsync", 32'(hsync), 32'd1);
        check("arst_active", 32'(active), 32'd0);
        check("arst_pixel", 32'(pixel), 32'd0);
        check("arst_rden", 32'(rden), 32'd0);
        check("arst_raddr", 32'(raddr), 32'd0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        s_rd = rd_count; s_serr = sync_err;
        wait_pos(0, 0);
        check("post_rst_sync", 32'(sync_err - s_serr), 32'd0);
        s_rd = rd_count; s_pix = pix_hi;
        wait_pos(0, 0);
        check("resume_reads", 32'(rd_count - s_rd), 32'd16);
        check("resume_pix_hi", 32'(pix_hi - s_pix), 32'd255);

        // loaded drops mid-frame: the frame completes, and the next one is dark.
        s_rd = rd_count;
        wait_pos(0, 5);
        loaded = 1'b0;
        wait_pos(0, 0);
        check("drop_frame_reads", 32'(rd_count - s_rd), 32'd16);
        s_rd = rd_count; s_pix = pix_hi;
        wait_pos(0, 0);
        check("dark_reads", 32'(rd_count - s_rd), 32'd0);
        check("dark_pix_hi", 32'(pix_hi - s_pix), 32'd0);

        check("total_sync_err", 32'(sync_err), 32'd0);
        check("total_read_err", 32'(rd_err), 32'd0);
        check("total_pix_err", 32'(pix_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Display-side reader for the video RAM. Generates 640×480@60 VGA timing from the pixel clock, fetches 16-bit screen words over the VRAM read port (`rden`/`raddr`/`out`), and serializes them into a 1-bit pixel stream. It places the 512×256 Hack screen in a centred window with a black border. It sits between the VRAM block and the board's VGA pins, and stays dark until VRAM reports `loaded`.

## Interface
Parameters:
- H_VISIBLE, 640, visible columns
- H_FRONT, 16, h front porch
- H_SYNC, 96, h sync width
- H_BACK, 48, h back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, v front porch
- V_SYNC, 2, v sync width
- V_BACK, 33, v back porch
- IMG_X, 64, first image column
- IMG_Y, 112, first image line

Ports:
- clk  in  1  pixel clock; sole clock
- reset_n  in  1  asynchronous, active-low reset
- loaded  in  1  VRAM load complete; level signal
- rden  out  1  VRAM read enable
- raddr  out  14  VRAM word address
- rdata  in  16  VRAM read data; valid the cycle after `raddr` was presented, only while `rden`=1 in that cycle
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- active  out  1  inside the 640×480 visible area
- pixel  out  1  1 = white, 0 = black

## Operation
- Counters:
  - `hcount` runs 0..799 and wraps.
  - `vcount` runs 0..524; it increments when `hcount` wraps and itself wraps to 0 after 524.
- Sync:
  - hsync low for `hcount` in [656, 751].
  - vsync low for `vcount` in [490, 491].
  - active = `hcount`<640 && `vcount`<480.
- Image window:
  - Columns IMG_X..IMG_X+511, lines IMG_Y..IMG_Y+255.
  - Image coordinates: x' = `hcount`−IMG_X, y' = `vcount`−IMG_Y.
- Word address: `raddr` = y'·32 + x'/16, so bit 13 is always 0. Rows are 32 words; the frame is 8192 words (0..8191).
- Bit order: image pixel x' is bit (x' mod 16) of its word, LSB leftmost.
  - Hack bit 1 = black, so `pixel` = ~bit.
- Outside the image window but inside the visible area (border): `pixel`=0. During blanking: `pixel`=0.
- Enable latch `scan_en`:
  - Cleared by reset.
  - Set only at `hcount`=0 && `vcount`=0 while `loaded`=1.
  - Cleared at the same point if `loaded`=0.
  - A `loaded` rise mid-frame therefore takes effect at the next frame start; no torn first frame.
- While `scan_en`=0: `rden`=0, `raddr`=0, image pixels output 0. Sync and active run normally.
- Fetch pipeline, per image line while `scan_en`=1:
  - Word k (0..31) is addressed in the cycle where `hcount` = IMG_X+16k−2. In that cycle `raddr` = word address and `rden`=1.
  - `rden` stays 1 through `hcount` = IMG_X+16k−1. In that cycle `rdata` is captured into a 16-bit holding register.
  - At `hcount` = IMG_X+16k the holding register loads the 16-bit shift register. The shift register then shifts right one bit per cycle; bit 0 drives the image pixel.
- `rden`=0 in every cycle not listed above.
- Exactly 32 reads per image line and 8192 per frame. No reads outside image lines.

## Timing
- Output registration: `hsync`, `vsync`, `active`, `pixel` are registered and lag the counters by exactly 1 cycle. Example: the image pixel for x' appears on `pixel` in the cycle after `hcount` = IMG_X+x'.
- `rden` and `raddr` are registered. "Addressed in cycle c" means the value is visible on the port during cycle c.
- Read latency: 1 cycle from address to `rdata`. This matches the SPRAM's registered read, whose output is zeroed when `rden`=0.
- Reset values, held while `reset_n`=0:
  - `hcount`=`vcount`=0, `scan_en`=0.
  - `hsync`=1, `vsync`=1, `active`=0, `pixel`=0.
  - `rden`=0, `raddr`=0, shift and holding registers 0.
- Reset released mid-line or mid-frame: the block restarts at `hcount`=`vcount`=0. The first image appears in the first frame that starts with `loaded`=1.
- `loaded` falling mid-frame: the current frame completes, and scanout stops at the next frame start.
- Line boundary: the last word (k=31) shifts out through x'=511. The shift register is not reloaded until the next image line. Border pixels never come from stale shift data.

## Test plan
- Reset, then hold `loaded`=0 for 2 frames → `rden` never 1. `hsync` low 96 cycles per 800. `vsync` low 2 lines per 525. `active` high 640×480 per frame. `pixel` always 0.
- Assert `loaded`=1 mid-frame (`vcount`=200); VRAM model word[a]=a → no `rden` until `vcount`=IMG_Y of the next frame. Exactly 8192 reads follow, addresses 0..8191 in order, one per 16 cycles within each line.
- VRAM model word[a]=16'h0001 → each 16-pixel group on `pixel`, one cycle after `hcount`=IMG_X+16k, reads 0,1,1,…,1 (leftmost black). Border and blanking pixels are 0.
- VRAM model word[33]=16'h8000, all other words 0 → `pixel`=0 only at image line 1, x'=31. That is `vcount`=113, and it appears the cycle after `hcount`=95. `pixel`=1 at every other image position.
- Pulse `reset_n` low for 3 cycles mid-line (`hcount`=300, `vcount`=150) → outputs take reset values asynchronously. After release the counters restart at 0, and the image resumes the frame after.
- Drop `loaded` at `vcount`=300 → reads continue to the end of the current frame, then stop. The next frame's image pixels are all 0.
